// File: rtl/ddr3_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_write_arbiter
// Brief    : Burst-granular round-robin arbiter that shares one DDR3
//            Avalon-MM write port among NUM_REQ burst-writing masters.
//            The grant is held for a whole burst, so beats never interleave.
//            Optional statistics counters are built when the macro
//            DDR3_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_write_arbiter #(
    parameter int NUM_REQ = 2,   // number of requesters, 2..4
    parameter int ADDR_W  = 27,  // Avalon word address width
    parameter int DATA_W  = 256, // data beat width
    parameter int BC_W    = 8    // burstcount width
) (
    input  logic                      ddr3_clk,
    input  logic                      ddr3_clk_reset,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*BC_W-1:0]   req_burstcount,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [ADDR_W-1:0]         ddr3_write_address,
    output logic [DATA_W-1:0]         ddr3_write_data,
    output logic                      ddr3_write,
    output logic [BC_W-1:0]           ddr3_burstcount,
    input  logic                      ddr3_waitrequest,
    output logic [1:0]                grant_index,
    output logic                      arb_busy
`ifdef DDR3_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     arb_burst_count,
    output logic [31:0]               arb_stall_count
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    // Per-requester slices are unpacked into 4-entry tables (the maximum
    // requester count) so that the 2-bit grant index addresses them exactly;
    // unused entries read as zero and never win arbitration.
    localparam int c_MAX_REQ = 4;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [1:0]      r_grant;
    logic [1:0]      r_last_grant;
    logic [BC_W-1:0] r_beats_left;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_addr_arr [0:c_MAX_REQ-1];
    logic [DATA_W-1:0] w_data_arr [0:c_MAX_REQ-1];
    logic [BC_W-1:0]   w_bc_arr   [0:c_MAX_REQ-1];
    logic [c_MAX_REQ-1:0] w_wr_vec;

    logic [0:0]      w_state_nxt;
    logic [1:0]      w_grant_nxt;
    logic [1:0]      w_last_grant_nxt;
    logic [BC_W-1:0] w_beats_left_nxt;

    logic            w_found;
    logic [1:0]      w_pick;
    logic [1:0]      w_cand;
    logic [BC_W-1:0] w_pick_bc;
    logic            w_in_burst;
    logic            w_beat_acc;
    logic            w_burst_done;

    // ------------------------------------------------------------------------
    // Unpack the flat per-requester buses into indexable tables
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < c_MAX_REQ; gi++) begin : g_slice
            if (gi < NUM_REQ) begin : g_live
                assign w_addr_arr[gi] = req_address[gi*ADDR_W +: ADDR_W];
                assign w_data_arr[gi] = req_write_data[gi*DATA_W +: DATA_W];
                assign w_bc_arr[gi]   = req_burstcount[gi*BC_W +: BC_W];
                assign w_wr_vec[gi]   = req_write[gi];
            end else begin : g_pad
                assign w_addr_arr[gi] = '0;
                assign w_data_arr[gi] = '0;
                assign w_bc_arr[gi]   = '0;
                assign w_wr_vec[gi]   = 1'b0;
            end
        end
    endgenerate

    assign w_in_burst   = (r_state == c_ST_BURST);
    assign w_beat_acc   = w_in_burst && ddr3_write && !ddr3_waitrequest;
    // A burst whose final beat is accepted this cycle; beats_left can only be
    // zero in the burst state after a corrupted load, so treat it like one.
    assign w_burst_done = w_beat_acc && (r_beats_left <= BC_W'(1));

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = 2'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && w_wr_vec[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // A burstcount of zero is served as a single beat
    assign w_pick_bc = (w_bc_arr[w_pick] == '0) ? BC_W'(1) : w_bc_arr[w_pick];

    // Next-state logic: grant in idle, count accepted beats in burst
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_beats_left_nxt = r_beats_left;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt      = c_ST_BURST;
                    w_grant_nxt      = w_pick;
                    w_beats_left_nxt = w_pick_bc;
                end
            end
            c_ST_BURST: begin
                if (w_beat_acc) begin
                    w_beats_left_nxt = r_beats_left - BC_W'(1);
                end
                if (w_burst_done) begin
                    w_state_nxt      = c_ST_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register; last_grant resets to the top requester so 0 wins first
    always_ff @(posedge ddr3_clk) begin
        if (ddr3_clk_reset) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= 2'(NUM_REQ - 1);
            r_beats_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beats_left <= w_beats_left_nxt;
        end
    end

    // Controller-side mux: only the granted requester is forwarded in a burst
    always_comb begin
        ddr3_write         = 1'b0;
        ddr3_write_address = '0;
        ddr3_write_data    = '0;
        ddr3_burstcount    = '0;
        if (w_in_burst) begin
            ddr3_write         = w_wr_vec[r_grant];
            ddr3_write_address = w_addr_arr[r_grant];
            ddr3_write_data    = w_data_arr[r_grant];
            ddr3_burstcount    = w_bc_arr[r_grant];
        end
    end

    // Requester-side waitrequest: the owner sees the controller, others stall
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_waitreq
            assign req_waitrequest[gi] = (w_in_burst && (r_grant == 2'(gi)))
                                         ? ddr3_waitrequest : 1'b1;
        end
    endgenerate

    assign grant_index = r_grant;
    assign arb_busy    = w_in_burst;

`ifdef DDR3_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics: completed bursts per requester and controller stall cycles
    // ------------------------------------------------------------------------
    logic [31:0] r_stall_cnt;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_burst_cnt
            logic [31:0] r_cnt;

            // Count bursts completed by this requester
            always_ff @(posedge ddr3_clk) begin
                if (ddr3_clk_reset) begin
                    r_cnt <= '0;
                end else if (w_burst_done && (r_grant == 2'(gi))) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end

            assign arb_burst_count[gi*32 +: 32] = r_cnt;
        end
    endgenerate

    // Count cycles where a forwarded beat is held off by the controller
    always_ff @(posedge ddr3_clk) begin
        if (ddr3_clk_reset) begin
            r_stall_cnt <= '0;
        end else if (w_in_burst && ddr3_write && ddr3_waitrequest) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign arb_stall_count = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_write_arbiter
// Brief    : Self-checking bench for ddr3_write_arbiter. A table of burst
//            scenarios drives two requester models and a controller model;
//            the expected beat stream is queued up front and popped as the
//            controller accepts beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_write_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 256;
    localparam int BC_W    = 8;

    logic                      ddr3_clk = 1'b0;
    logic                      ddr3_clk_reset;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_write_data;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*BC_W-1:0]   req_burstcount;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [ADDR_W-1:0]         ddr3_write_address;
    logic [DATA_W-1:0]         ddr3_write_data;
    logic                      ddr3_write;
    logic [BC_W-1:0]           ddr3_burstcount;
    logic                      ddr3_waitrequest;
    logic [1:0]                grant_index;
    logic                      arb_busy;
`ifdef DDR3_ARB_STATS_EN
    logic [NUM_REQ*32-1:0]     arb_burst_count;
    logic [31:0]               arb_stall_count;
`endif

    ddr3_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .BC_W    (BC_W)
    ) dut (
        .ddr3_clk           (ddr3_clk),
        .ddr3_clk_reset     (ddr3_clk_reset),
        .req_address        (req_address),
        .req_write_data     (req_write_data),
        .req_write          (req_write),
        .req_burstcount     (req_burstcount),
        .req_waitrequest    (req_waitrequest),
        .ddr3_write_address (ddr3_write_address),
        .ddr3_write_data    (ddr3_write_data),
        .ddr3_write         (ddr3_write),
        .ddr3_burstcount    (ddr3_burstcount),
        .ddr3_waitrequest   (ddr3_waitrequest),
        .grant_index        (grant_index),
        .arb_busy           (arb_busy)
`ifdef DDR3_ARB_STATS_EN
        ,
        .arb_burst_count    (arb_burst_count),
        .arb_stall_count    (arb_stall_count)
`endif
    );

    always #5 ddr3_clk = ~ddr3_clk;

    typedef struct {
        int      bc0, bc1;        // burstcount per requester
        int      nb0, nb1;        // bursts to issue per requester
        int      stall_at;        // controller stalls when this beat appears
        int      stall_len;       // stall cycles (0 = none)
        int      gap_req;         // requester that pauses mid-burst
        int      gap_after;       // pause after this beat of its first burst
        int      gap_len;         // pause cycles (0 = none)
        bit [15:0] order;         // expected grant order, 2 bits per burst
        int      n_ord;           // number of bursts in order
        bit      chk_gap;         // check the single idle cycle between bursts
    } row_t;

    typedef struct {
        int                req;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                first;
    } beat_t;

    beat_t sb[$];
    row_t  rows[7];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int rq_bc[2], rq_nb[2], rq_done[2], rq_beat[2];
    bit acc[2];
    int gap_req, gap_after, gap_len, gap_cnt;
    bit gap_used;
    int stall_at, stall_len, stall_left;
    bit stall_used;
    int tot_acc, req_cycle, last_beat_cyc;
    bit first_seen, chk_gap;

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [ADDR_W-1:0] f_addr(input int r, input int b);
        return ADDR_W'(32'h0010_0000 * (r + 1) + b * 64);
    endfunction

    function automatic logic [DATA_W-1:0] f_data(input int r, input int b, input int beat);
        logic [31:0] w;
        w = 32'(r * 7 + b * 3 + 1);
        return {{7{w}}, 8'(r), 8'(b), 8'(beat), 8'hA5};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive both requester models from their current burst/beat position
    task automatic drive_reqs();
        for (int i = 0; i < 2; i++) begin
            bit on;
            on = (rq_done[i] < rq_nb[i]) && !(gap_cnt > 0 && gap_req == i);
            req_write[i] = on;
            req_address[i*ADDR_W +: ADDR_W]    = f_addr(i, rq_done[i]);
            req_write_data[i*DATA_W +: DATA_W] = f_data(i, rq_done[i], rq_beat[i]);
            req_burstcount[i*BC_W +: BC_W]     = BC_W'(rq_bc[i]);
            if (on && req_cycle < 0) req_cycle = cyc;
        end
        if (gap_cnt > 0) gap_cnt--;
    endtask

    // Mid-cycle observation of the controller side and requester handshakes
    task automatic monitor();
        beat_t e;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        if (ddr3_clk_reset) return;
        for (int i = 0; i < 2; i++) acc[i] = req_write[i] && !req_waitrequest[i];
        if (ddr3_write && !ddr3_waitrequest) begin
            tot_acc++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", 256'(1), 256'(0));
            end else begin
                e = sb.pop_front();
                chk("beat_req",  256'(grant_index), 256'(e.req));
                chk("beat_addr", 256'(ddr3_write_address), 256'(e.addr));
                chk("beat_data", ddr3_write_data, e.data);
                chk("beat_bc",   256'(ddr3_burstcount), 256'(rq_bc[e.req]));
                chk("other_waitreq", 256'(req_waitrequest[1-e.req]), 256'(1));
                if (e.first) begin
                    if (!first_seen) chk("arb_latency", 256'(cyc - req_cycle), 256'(1));
                    else if (chk_gap) chk("idle_gap", 256'(cyc - last_beat_cyc), 256'(2));
                    first_seen = 1'b1;
                end
                last_beat_cyc = cyc;
            end
        end else if (ddr3_write && ddr3_waitrequest && sb.size() > 0) begin
            chk("stall_data",    ddr3_write_data, sb[0].data);
            chk("stall_reqwait", 256'(req_waitrequest[sb[0].req]), 256'(1));
        end else if (arb_busy && sb.size() > 0) begin
            chk("hold_grant", 256'(grant_index), 256'(sb[0].req));
        end
    endtask

    // One clock: observe at negedge, then update models and drive after posedge
    task automatic step();
        @(negedge ddr3_clk);
        monitor();
        @(posedge ddr3_clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                rq_beat[i]++;
                if (gap_req == i && !gap_used && gap_len > 0 && rq_done[i] == 0 &&
                    rq_beat[i] == gap_after) begin
                    gap_used = 1'b1;
                    gap_cnt  = gap_len;
                end
                if (rq_beat[i] >= max1(rq_bc[i])) begin
                    rq_beat[i] = 0;
                    rq_done[i]++;
                end
            end
        end
        if (!stall_used && stall_len > 0 && tot_acc == stall_at - 1) begin
            stall_used = 1'b1;
            stall_left = stall_len;
        end
        if (stall_left > 0) begin
            ddr3_waitrequest = 1'b1;
            stall_left--;
        end else begin
            ddr3_waitrequest = 1'b0;
        end
        drive_reqs();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            rq_done[i] = 0;
            rq_beat[i] = 0;
        end
        gap_cnt = 0;  gap_used = 1'b0;
        stall_left = 0; stall_used = 1'b0;
        tot_acc = 0;  req_cycle = -1; last_beat_cyc = 0;
        first_seen = 1'b0;
        sb.delete();
    endtask

    task automatic push_order(input bit [15:0] order, input int n_ord);
        int cnt[2];
        cnt[0] = 0;
        cnt[1] = 0;
        for (int k = 0; k < n_ord; k++) begin
            int rr;
            rr = int'(order[2*k +: 2]);
            for (int b = 0; b < max1(rq_bc[rr]); b++) begin
                beat_t e;
                e.req   = rr;
                e.addr  = f_addr(rr, cnt[rr]);
                e.data  = f_data(rr, cnt[rr], b);
                e.first = (b == 0);
                sb.push_back(e);
            end
            cnt[rr]++;
        end
    endtask

    task automatic run_until_drained(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 3000) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, 256'(sb.size()), 256'(0));
    endtask

    task automatic run_row(input int idx, input row_t r);
        ddr3_clk_reset = 1'b1;
        rq_nb[0] = 0; rq_nb[1] = 0;
        gap_len = 0;  stall_len = 0;
        clear_model();
        step();
        step();
        rq_bc[0] = r.bc0; rq_bc[1] = r.bc1;
        rq_nb[0] = r.nb0; rq_nb[1] = r.nb1;
        gap_req = r.gap_req; gap_after = r.gap_after; gap_len = r.gap_len;
        stall_at = r.stall_at; stall_len = r.stall_len;
        chk_gap = r.chk_gap;
        clear_model();
        push_order(r.order, r.n_ord);
        ddr3_clk_reset = 1'b0;
        run_until_drained($sformatf("row%0d", idx));
        chk($sformatf("row%0d_busy_after", idx),  256'(arb_busy),   256'(0));
        chk($sformatf("row%0d_write_after", idx), 256'(ddr3_write), 256'(0));
`ifdef DDR3_ARB_STATS_EN
        chk($sformatf("row%0d_burst_cnt0", idx), 256'(arb_burst_count[31:0]),  256'(r.nb0));
        chk($sformatf("row%0d_burst_cnt1", idx), 256'(arb_burst_count[63:32]), 256'(r.nb1));
        chk($sformatf("row%0d_stall_cnt", idx),  256'(arb_stall_count),        256'(r.stall_len));
`endif
    endtask

    initial begin
        //            bc0 bc1 nb0 nb1 st_at st_len gap_r gap_af gap_len order     n  chk_gap
        rows[0] = '{8,  8,  1,  0,  0,    0,     0,    0,     0,    16'h0000, 1, 1'b0};
        rows[1] = '{8,  8,  2,  2,  0,    0,     0,    0,     0,    16'h0044, 4, 1'b1};
        rows[2] = '{8,  8,  1,  0,  4,    3,     0,    0,     0,    16'h0000, 1, 1'b0};
        rows[3] = '{8,  8,  1,  1,  0,    0,     0,    2,     2,    16'h0004, 2, 1'b1};
        rows[4] = '{3,  0,  3,  0,  0,    0,     0,    0,     0,    16'h0000, 3, 1'b1};
        rows[5] = '{2,  2,  5,  3,  2,    4,     0,    0,     0,    16'h0444, 8, 1'b0};
        rows[6] = '{1,  0,  0,  2,  0,    0,     0,    0,     0,    16'h0005, 2, 1'b1};

        // Reset state
        ddr3_clk_reset   = 1'b1;
        ddr3_waitrequest = 1'b0;
        req_write = '0; req_address = '0; req_write_data = '0; req_burstcount = '0;
        rq_bc[0] = 0; rq_bc[1] = 0; rq_nb[0] = 0; rq_nb[1] = 0;
        gap_req = 0; gap_after = 0; gap_len = 0; stall_at = 0; stall_len = 0;
        chk_gap = 1'b0;
        clear_model();
        step();
        step();
        chk("rst_write",   256'(ddr3_write),         256'(0));
        chk("rst_waitreq", 256'(req_waitrequest),    256'(2'b11));
        chk("rst_grant",   256'(grant_index),        256'(0));
        chk("rst_busy",    256'(arb_busy),           256'(0));
        chk("rst_addr",    256'(ddr3_write_address), 256'(0));

        for (int i = 0; i < 7; i++) run_row(i, rows[i]);

        // Reset in the middle of a burst, then check that requester 0 wins first
        ddr3_clk_reset = 1'b1;
        rq_nb[0] = 0; rq_nb[1] = 0; gap_len = 0; stall_len = 0;
        clear_model();
        step();
        step();
        rq_bc[0] = 8; rq_bc[1] = 8; rq_nb[0] = 1; rq_nb[1] = 1;
        chk_gap = 1'b0;
        clear_model();
        for (int b = 0; b < 3; b++) begin
            beat_t e;
            e.req = 0; e.addr = f_addr(0, 0); e.data = f_data(0, 0, b); e.first = (b == 0);
            sb.push_back(e);
        end
        ddr3_clk_reset = 1'b0;
        run_until_drained("pre_reset");
        ddr3_clk_reset = 1'b1;
        step();
        chk("midrst_write",   256'(ddr3_write),      256'(0));
        chk("midrst_waitreq", 256'(req_waitrequest), 256'(2'b11));
        chk("midrst_grant",   256'(grant_index),     256'(0));
        chk("midrst_busy",    256'(arb_busy),        256'(0));
        rq_nb[0] = 1; rq_nb[1] = 1;
        clear_model();
        push_order(16'h0004, 2);
        ddr3_clk_reset = 1'b0;
        drive_reqs();
        run_until_drained("post_reset");
        chk("post_reset_busy", 256'(arb_busy), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr3_write_arbiter.md
Name: ddr3_write_arbiter

Overview:
- Shares the single DDR3 Avalon-MM write port among NUM_REQ burst-writing masters, e.g. the left- and right-camera pixel writers.
- Arbitration is burst-granular and round-robin.
- The grant is held for the full burst, so beats from different requesters never interleave.
- Sits between the pixel writers and the DDR3 controller, entirely in the ddr3_clk domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 27, Avalon word address width.
- DATA_W, 256, data beat width.
- BC_W, 8, burstcount width.

Ports:
- ddr3_clk  in  1  clock.
- ddr3_clk_reset  in  1  synchronous active-high reset.
- req_address  in  NUM_REQ*ADDR_W  per-requester address; slice i belongs to requester i.
- req_write_data  in  NUM_REQ*DATA_W  per-requester write data.
- req_write  in  NUM_REQ  per-requester write strobe.
- req_burstcount  in  NUM_REQ*BC_W  per-requester burstcount.
- req_waitrequest  out  NUM_REQ  per-requester waitrequest.
- ddr3_write_address  out  ADDR_W  to controller.
- ddr3_write_data  out  DATA_W  to controller.
- ddr3_write  out  1  to controller.
- ddr3_burstcount  out  BC_W  to controller.
- ddr3_waitrequest  in  1  from controller.
- grant_index  out  2  currently or last granted requester.
- arb_busy  out  1  high while a burst is owned.

Behaviour:
- Clocking and reset: one clock (ddr3_clk); reset ddr3_clk_reset is synchronous, active-high.
- Reset values:
  - state=ST_IDLE, arb_busy=0, ddr3_write=0, req_waitrequest all 1.
  - grant_index=0, last_grant=NUM_REQ-1 (requester 0 wins first), beat counter=0.
- ST_IDLE:
  - If any req_write is high, pick the first requester with req_write=1 searching last_grant+1, +2, ... modulo NUM_REQ.
  - Register grant_index, latch that requester's burstcount into beats_left (burstcount 0 is treated as 1), go to ST_BURST.
  - No beat is accepted in ST_IDLE.
  - Arbitration latency: exactly 1 cycle from request to first forwardable beat.
- ST_BURST, combinational mux from granted requester g:
  - ddr3_write = req_write[g].
  - ddr3_write_address, ddr3_write_data, ddr3_burstcount = slice g.
  - req_waitrequest[g] = ddr3_waitrequest; all others held at 1.
- ST_BURST, beat accounting:
  - A beat is accepted when ddr3_write && !ddr3_waitrequest; each accepted beat decrements beats_left.
  - On the accepted beat with beats_left==1: last_grant<=g, go to ST_IDLE.
  - The next grant is therefore evaluated one cycle later; a new burst never starts in the cycle the previous one ends.
- Outside ST_BURST: ddr3_write=0, address/data/burstcount outputs=0.
- Gaps: req_write[g] low mid-burst is legal. Nothing is forwarded, the grant is held, and the state does not change.
- Stalls: ddr3_waitrequest high holds all muxed outputs stable; beats_left is unchanged.
- Width rule: beats_left is BC_W bits; burstcount ≤ 2^BC_W-1 is guaranteed by requesters.
- Fairness:
  - With all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.
  - A lone requester is re-granted back to back with one idle cycle between bursts.
- Simultaneous events:
  - Requests arriving during ST_BURST wait, each seeing req_waitrequest=1.
  - The final beat and a new request in the same cycle are resolved in ST_IDLE the following cycle.
- Reset mid-burst: returns immediately to reset values and the in-flight burst is abandoned. Reset is only asserted system-wide, so the controller and requesters reset together.
- arb_busy = (state==ST_BURST).

Optional Feature:
- Macro: DDR3_ARB_STATS_EN.
- With the macro defined, adds output arb_burst_count[NUM_REQ*32] (one 32-bit counter per requester) and output arb_stall_count[32]:
  - arb_burst_count[i] increments on completion of each burst by requester i.
  - arb_stall_count increments every ST_BURST cycle with ddr3_write && ddr3_waitrequest.
  - All counters are cleared by reset and wrap at 2^32.
- Without the macro, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Requester 0 alone, burstcount=8, waitrequest=0 -> grant on cycle 1, 8 beats forwarded on cycles 2..9 with address from slice 0, arb_busy falls after beat 8, req_waitrequest[1] stays 1 throughout.
- Requesters 0 and 1 both asserting continuous 8-beat bursts -> grant order 0,1,0,1; beats never interleave; exactly one idle cycle between bursts.
- ddr3_waitrequest high for 3 cycles during beat 4 of 8 -> outputs frozen with beat-4 data, req_waitrequest[g]=1 for those cycles, burst still ends after exactly 8 accepted beats.
- Granted requester drops req_write for 2 cycles after beat 2 -> ddr3_write=0 for those cycles, grant held, remaining 6 beats complete, requester 1 waiting meanwhile is not granted early.
- ddr3_clk_reset asserted after beat 3 of 8 -> next cycle ddr3_write=0, req_waitrequest all 1, grant_index=0; after release, requester 0 is granted first.
- DDR3_ARB_STATS_EN defined, 5 bursts from req 0, 3 from req 1, 4 stall cycles -> arb_burst_count = {3,5} (slice 1, slice 0), arb_stall_count=4.
